// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM type and sizing helpers for the systolic multiplier
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Terminal counter value: the edge on which the far-corner PE receives its last term
    function automatic int latency(input int n);
        return 3 * n - 3;
    endfunction

    // Width of the run counter, wide enough to hold 0..latency(n)
    function automatic int cnt_width(input int n);
        return $clog2(3 * n - 2);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one multiply-accumulate cell; SYSTOLIC_SAT_EN selects saturating accumulation
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    // A start edge discards the previous run's sum instead of adding to it
    assign w_base = clr ? '0 : r_acc;

`ifdef SYSTOLIC_SAT_EN
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH:0]   w_sum;

    assign w_prod = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
    assign w_sum  = {1'b0, w_prod} + {{(WIDTH+1){1'b0}}, w_base};
    assign w_next = (|w_sum[2*WIDTH:WIDTH]) ? '1 : w_sum[WIDTH-1:0];
`else
    logic [WIDTH-1:0] w_prod;

    assign w_prod = a_in * b_in;
    assign w_next = w_base + w_prod;
`endif

    // Operand pipeline shifts every edge; the accumulator only moves while enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= a_in;
            r_b <= b_in;
            if (en) begin
                r_acc <= w_next;
            end
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign acc   = r_acc;

endmodule

// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - NxN output-stationary systolic matrix multiplier with run FSM and edge gating
module systolic_array
    import systolic_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] array [1:0][N-1:0],
    output logic [WIDTH-1:0] Data  [N-1:0][N-1:0],
    output logic             finish
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(latency(N));
    localparam logic [CW-1:0] WIN  = CW'(2 * N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             w_start_edge;
    logic             w_acc_en;
    logic             w_in_window;
    logic [WIDTH-1:0] w_a_edge   [N];
    logic [WIDTH-1:0] w_b_edge   [N];
    logic [WIDTH-1:0] w_a_out    [N][N-1];
    logic [WIDTH-1:0] w_b_out    [N-1][N];
    logic [WIDTH-1:0] w_unused_a [N];
    logic [WIDTH-1:0] w_unused_b [N];

    // r_cnt holds the input-cycle index of the current cycle; the start edge itself is cycle 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start_edge = 1'b0;
        finish       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_cnt_next   = CW'(1);
                    w_start_edge = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DONE: begin
                finish = 1'b1;
                if (start) begin
                    w_state_next = RUN;
                    w_cnt_next   = CW'(1);
                    w_start_edge = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_acc_en    = w_start_edge | (r_state == RUN);
    assign w_in_window = w_start_edge | ((r_state == RUN) && (r_cnt < WIN));

    // Edge streams are zeroed outside the skew window so stale pipeline data never accumulates
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_a_edge[k] = w_in_window ? array[0][k] : '0;
            w_b_edge[k] = w_in_window ? array[1][k] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [WIDTH-1:0] w_a_in;
            logic [WIDTH-1:0] w_b_in;
            logic [WIDTH-1:0] w_a_o;
            logic [WIDTH-1:0] w_b_o;

            if (j == 0) begin : g_a_west
                assign w_a_in = w_a_edge[i];
            end else begin : g_a_left
                assign w_a_in = w_a_out[i][j-1];
            end

            if (i == 0) begin : g_b_north
                assign w_b_in = w_b_edge[j];
            end else begin : g_b_up
                assign w_b_in = w_b_out[i-1][j];
            end

            if (j < N - 1) begin : g_a_fwd
                assign w_a_out[i][j] = w_a_o;
            end else begin : g_a_sink
                assign w_unused_a[i] = w_a_o;
            end

            if (i < N - 1) begin : g_b_fwd
                assign w_b_out[i][j] = w_b_o;
            end else begin : g_b_sink
                assign w_unused_b[j] = w_b_o;
            end

            systolic_pe #(
                .WIDTH(WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (w_start_edge),
                .en   (w_acc_en),
                .a_in (w_a_in),
                .b_in (w_b_in),
                .a_out(w_a_o),
                .b_out(w_b_o),
                .acc  (Data[i][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - self-checking bench for systolic_array against a matrix-product model
module tb_systolic_array;

    localparam int N     = 2;
    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int LAT   = 3 * N - 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] arr  [1:0][N-1:0];
    logic [WIDTH-1:0] dout [N-1:0][N-1:0];
    logic             finish;

    int checks   = 0;
    int failures = 0;

    int cur_a [N][N];
    int cur_b [N][N];
    int cap_a [N][N];
    int cap_b [N][N];
    int exp_data [N][N];

    bit m_busy  = 1'b0;
    bit m_fin   = 1'b0;
    bit m_zero  = 1'b0;
    int m_edges = 0;

    systolic_array #(
        .N    (N),
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .array (arr),
        .Data  (dout),
        .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    // C[i][j] from the plain matrix product of the operands captured at the start edge
    function automatic int model_c(input int i, input int j);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += cap_a[i][k] * cap_b[k][j];
        end
`ifdef SYSTOLIC_SAT_EN
        return (s > MAXV) ? MAXV : s;
`else
        return s % (MAXV + 1);
`endif
    endfunction

    // Model tracks runs by edge count only, then checks finish every cycle and Data whenever defined
    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_busy = 1'b0;
            m_fin  = 1'b0;
            m_zero = 1'b1;
        end else if (start && !m_busy) begin
            m_busy  = 1'b1;
            m_fin   = 1'b0;
            m_zero  = 1'b0;
            m_edges = 0;
            cap_a   = cur_a;
            cap_b   = cur_b;
        end else if (m_busy) begin
            m_edges++;
            if (m_edges == LAT) begin
                m_busy = 1'b0;
                m_fin  = 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        exp_data[i][j] = model_c(i, j);
                    end
                end
            end
        end
        #1;
        chk("finish", finish, m_fin);
        if (m_fin || m_zero) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    chk($sformatf("data[%0d][%0d]", i, j), dout[i][j], m_fin ? exp_data[i][j] : 0);
                end
            end
        end
    end

    // Skewed beat for input cycle t; outside the window the bus carries random junk
    task automatic drive(input int t);
        for (int i = 0; i < N; i++) begin
            if (t >= 0 && t <= 2 * N - 2) begin
                arr[0][i] = '0;
                arr[1][i] = '0;
                if (t - i >= 0 && t - i < N) begin
                    arr[0][i] = WIDTH'(cur_a[i][t-i]);
                    arr[1][i] = WIDTH'(cur_b[t-i][i]);
                end
            end else begin
                arr[0][i] = WIDTH'($urandom);
                arr[1][i] = WIDTH'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            start = 1'b0;
            rst_n = 1'b1;
            drive(-1);
            @(negedge clk);
        end
    endtask

    // One run of 3N-2 edges; optional extra start pulse and optional reset at a given input cycle
    task automatic do_run(input int mid_start, input int rst_at);
        for (int t = 0; t < LAT + 1; t++) begin
            start = (t == 0) || (t == mid_start);
            rst_n = (t == rst_at) ? 1'b0 : 1'b1;
            drive(t);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        drive(-1);
    endtask

    task automatic check_lit(input string name, input int c00, input int c01, input int c10, input int c11);
        chk({name, "_finish"}, finish, 1);
        chk({name, "_c00"}, dout[0][0], c00);
        chk({name, "_c01"}, dout[0][1], c01);
        chk({name, "_c10"}, dout[1][0], c10);
        chk({name, "_c11"}, dout[1][1], c11);
    endtask

    task automatic set_nominal();
        cur_a = '{'{2, 4}, '{1, 3}};
        cur_b = '{'{2, 1}, '{1, 1}};
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        drive(-1);
        @(negedge clk);
        chk("reset_finish", finish, 0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk("reset_data", dout[i][j], 0);
            end
        end
        idle(2);

        set_nominal();
        do_run(-1, -1);
        check_lit("nominal", 8, 6, 5, 4);
        idle(2);

        cur_a = '{'{1, 0}, '{0, 1}};
        cur_b = '{'{3, 5}, '{7, 9}};
        do_run(-1, -1);
        check_lit("b2b", 3, 5, 7, 9);

        cur_a = '{'{15, 15}, '{0, 0}};
        cur_b = '{'{15, 0}, '{15, 0}};
        do_run(-1, -1);
`ifdef SYSTOLIC_SAT_EN
        check_lit("sat", 15, 0, 0, 0);
`else
        check_lit("wrap", 2, 0, 0, 0);
`endif
        idle(1);

        set_nominal();
        do_run(1, -1);
        check_lit("start_in_run", 8, 6, 5, 4);
        idle(1);

        do_run(-1, 2);
        chk("midrst_finish", finish, 0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk("midrst_data", dout[i][j], 0);
            end
        end
        idle(1);
        do_run(-1, -1);
        check_lit("after_rst", 8, 6, 5, 4);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    cur_a[i][j] = int'($urandom_range(0, MAXV));
                    cur_b[i][j] = int'($urandom_range(0, MAXV));
                end
            end
            idle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                do_run(int'($urandom_range(1, LAT)), -1);
            end else begin
                do_run(-1, -1);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
